// File: rtl/char_pwm_pkg.sv
// Shared constants, phase-counter state encoding and the default pattern table for char_pwm_seq.
package char_pwm_pkg;

  localparam int unsigned HOLD_W = 8;

  localparam logic [15:0] CHAR_A = 16'h9F8F;
  localparam logic [15:0] CHAR_J = 16'h6998;
  localparam logic [15:0] CHAR_N = 16'h9DA9;
  localparam logic [15:0] CHAR_X = 16'h9679;

  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_RUN  = 1'b1
  } phase_state_e;

  // Power-on content of one slot; the glyphs only make sense on a 16-pixel array.
  function automatic logic [15:0] default_char(input int unsigned n_pix, input int unsigned slot);
    logic [15:0] pat;
    pat = 16'h0000;
    if (n_pix == 16) begin
      case (slot)
        0:       pat = CHAR_A;
        1:       pat = CHAR_J;
        2:       pat = CHAR_N;
        3:       pat = CHAR_X;
        default: pat = 16'h0000;
      endcase
    end
    return pat;
  endfunction

endpackage

// File: rtl/char_pwm_phase_cnt.sv
// Carrier period counter: tracks the position inside the current period and flags period boundaries.
module char_pwm_phase_cnt
  import char_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] period_len,
  output logic             load_c,
  output logic             hi_c,
  output logic             running,
  output logic [CNT_W-1:0] cnt
);

  phase_state_e     state_q;
  phase_state_e     state_d;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W:0]   per_plus1;

  assign running = (state_q == PH_RUN);

  // Load on start-up and on the last count of each period.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (enable) begin
          load_c  = 1'b1;
          state_d = PH_RUN;
        end
      end
      PH_RUN: begin
        if (!enable) begin
          state_d = PH_IDLE;
        end else if (cnt == per_q) begin
          load_c = 1'b1;
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_IDLE;
      cnt     <= '0;
      per_q   <= CNT_W'(1);
    end else begin
      state_q <= state_d;
      if (!enable) begin
        cnt <= '0;
      end else if (load_c) begin
        cnt   <= '0;
        per_q <= (period_len == '0) ? CNT_W'(1) : period_len;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // High phase is floor(period/2) cycles, so odd periods get the shorter high phase.
  assign per_plus1 = {1'b0, per_q} + (CNT_W + 1)'(1);
  assign hi_c      = (cnt < per_plus1[CNT_W:1]);

endmodule

// File: rtl/char_pwm_seq.sv
// Phase-encoded character pattern generator with a writable slot table.
// Define CHAR_PWM_AUTOSEQ_EN to add the automatic slot sequencer (seq_en, hold_periods).
module char_pwm_seq
  import char_pwm_pkg::*;
#(
  parameter int unsigned N_PIX  = 16,
  parameter int unsigned N_CHAR = 4,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned SEL_W = $clog2(N_CHAR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period_len,
  input  logic [SEL_W-1:0]  char_select,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [SEL_W-1:0]  wr_addr,
  input  logic [N_PIX-1:0]  wr_data,
  output logic [N_PIX-1:0]  digit,
  output logic              frame_start,
  output logic [SEL_W-1:0]  active_char
`ifdef CHAR_PWM_AUTOSEQ_EN
  ,
  input  logic              seq_en,
  input  logic [HOLD_W-1:0] hold_periods
`endif
);

  localparam bit POW2 = ((1 << SEL_W) == N_CHAR);

  logic             load_c;
  logic             hi_c;
  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] sel_raw_c;
  logic [SEL_W-1:0] sel_c;
  logic             sel_ok_c;
  logic             addr_ok_c;
  logic [N_PIX-1:0] shadow;
  logic [N_PIX-1:0] pat_tbl [N_CHAR];

  char_pwm_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .period_len (period_len),
    .load_c     (load_c),
    .hi_c       (hi_c),
    .running    (running),
    .cnt        (cnt)
  );

`ifdef CHAR_PWM_AUTOSEQ_EN
  logic              seq_en_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SEL_W-1:0]  seq_idx;
  logic              seq_rise_c;
  logic [HOLD_W-1:0] hold_cur_c;
  logic [SEL_W-1:0]  seq_cur_c;

  // A fresh seq_en restarts the sweep from slot 0, even if a load coincides.
  assign seq_rise_c = seq_en && !seq_en_q;
  assign hold_cur_c = seq_rise_c ? '0 : hold_cnt;
  assign seq_cur_c  = seq_rise_c ? '0 : seq_idx;
  assign sel_raw_c  = seq_en ? seq_cur_c : char_select;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_en_q <= 1'b0;
      hold_cnt <= '0;
      seq_idx  <= '0;
    end else begin
      seq_en_q <= seq_en;
      hold_cnt <= hold_cur_c;
      seq_idx  <= seq_cur_c;
      if (seq_en && load_c) begin
        if (hold_cur_c == hold_periods) begin
          hold_cnt <= '0;
          seq_idx  <= (32'(seq_cur_c) == N_CHAR - 1) ? '0 : seq_cur_c + SEL_W'(1);
        end else begin
          hold_cnt <= hold_cur_c + HOLD_W'(1);
        end
      end
    end
  end
`else
  assign sel_raw_c = char_select;
`endif

  // Slot indices beyond N_CHAR only exist when N_CHAR is not a power of two.
  generate
    if (POW2) begin : g_pow2
      assign sel_ok_c  = 1'b1;
      assign addr_ok_c = 1'b1;
    end else begin : g_npow2
      assign sel_ok_c  = (32'(sel_raw_c) < N_CHAR);
      assign addr_ok_c = (32'(wr_addr) < N_CHAR);
    end
  endgenerate

  assign sel_c    = sel_ok_c ? sel_raw_c : '0;
  assign wr_ready = !rst && !load_c;

  // Pattern table; loads are excluded from write cycles so the shadow copy never races a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CHAR; i++) begin
        pat_tbl[i] <= N_PIX'(default_char(N_PIX, i));
      end
    end else if (wr_valid && wr_ready && addr_ok_c) begin
      pat_tbl[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      active_char <= '0;
      digit       <= '0;
      frame_start <= 1'b0;
    end else begin
      if (load_c) begin
        shadow      <= pat_tbl[sel_c];
        active_char <= sel_c;
      end
      // Active pixels follow the carrier, inactive pixels run in antiphase.
      if (enable && running) begin
        digit       <= hi_c ? shadow : ~shadow;
        frame_start <= (cnt == '0);
      end else begin
        digit       <= '0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_char_pwm_seq.sv
// Randomized scoreboard bench for char_pwm_seq against a period-level reference model.
module tb_char_pwm_seq;

  localparam int unsigned N_PIX  = 16;
  localparam int unsigned N_CHAR = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SEL_W  = 2;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [CNT_W-1:0]  period_len;
  logic [SEL_W-1:0]  char_select;
  logic              wr_valid;
  logic              wr_ready;
  logic [SEL_W-1:0]  wr_addr;
  logic [N_PIX-1:0]  wr_data;
  logic [N_PIX-1:0]  digit;
  logic              frame_start;
  logic [SEL_W-1:0]  active_char;
`ifdef CHAR_PWM_AUTOSEQ_EN
  logic              seq_en;
  logic [7:0]        hold_periods;
  initial begin
    seq_en       = 1'b0;
    hold_periods = 8'd0;
  end
`endif

  char_pwm_seq #(
    .N_PIX  (N_PIX),
    .N_CHAR (N_CHAR),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .period_len   (period_len),
    .char_select  (char_select),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .digit        (digit),
    .frame_start  (frame_start),
    .active_char  (active_char)
`ifdef CHAR_PWM_AUTOSEQ_EN
    ,
    .seq_en       (seq_en),
    .hold_periods (hold_periods)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        fs;
    logic [1:0]  ac;
  } out_t;

  typedef struct packed {
    logic [15:0] d;
    logic        fs;
  } word_t;

  out_t        exp_q[$];
  word_t       plan[$];
  logic [15:0] m_tbl [4];
  logic [1:0]  m_act;
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic m_reset();
    m_tbl[0] = 16'h9F8F;
    m_tbl[1] = 16'h6998;
    m_tbl[2] = 16'h9DA9;
    m_tbl[3] = 16'h9679;
    m_act    = 2'd0;
    plan.delete();
  endtask

  // Whole periods are queued as words when they start; the queue running dry marks a boundary.
  task automatic model_step();
    out_t        o;
    word_t       w;
    word_t       nw;
    bit          ld;
    int          p;
    logic [15:0] pat;
    o = '0;
    w = '0;
    if (rst) begin
      m_reset();
    end else begin
      ld = enable && (plan.size() <= 1);
      if (!enable) plan.delete();
      else if (plan.size() > 0) w = plan.pop_front();
      if (ld) begin
        p   = ((period_len == 0) ? 1 : int'(period_len)) + 1;
        pat = m_tbl[char_select];
        for (int k = 0; k < p; k++) begin
          nw.d  = (k < p / 2) ? pat : ~pat;
          nw.fs = (k == 0);
          plan.push_back(nw);
        end
        m_act = char_select;
      end else if (wr_valid) begin
        m_tbl[wr_addr] = wr_data;
      end
      o.d  = w.d;
      o.fs = w.fs;
      o.ac = m_act;
    end
    exp_q.push_back(o);
  endtask

  // One clock: model the edge, drive next inputs, then check the combinational handshake.
  task automatic cycle(input logic r, input logic en, input logic [7:0] pl, input logic [1:0] cs,
                       input logic wv, input logic [1:0] wa, input logic [15:0] wd);
    bit exp_rdy;
    @(posedge clk);
    model_step();
    #2;
    rst         = r;
    enable      = en;
    period_len  = pl;
    char_select = cs;
    wr_valid    = wv;
    wr_addr     = wa;
    wr_data     = wd;
    #1;
    exp_rdy = !r && !(en && plan.size() <= 1);
    check("wr_ready", 32'(wr_ready), 32'(exp_rdy));
  endtask

  initial begin : monitor
    out_t o;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        o = exp_q.pop_front();
        check("digit", 32'(digit), 32'(o.d));
        check("frame_start", 32'(frame_start), 32'(o.fs));
        check("active_char", 32'(active_char), 32'(o.ac));
      end
    end
  end

  initial begin : stimulus
    logic       en;
    logic [7:0] pl;
    logic [1:0] cs;
    rst = 1'b1; enable = 1'b0; period_len = 8'd3; char_select = 2'd0;
    wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 16'h0;
    m_reset();

    repeat (3) cycle(1, 0, 3, 0, 0, 0, 0);
    // Basic carrier, period 4 on slot 0.
    repeat (20) cycle(0, 1, 3, 0, 0, 0, 0);
    // Display slot 2, then overwrite it mid-period.
    repeat (9) cycle(0, 1, 3, 2, 0, 0, 0);
    repeat (3) cycle(0, 1, 3, 2, 1, 2, 16'h00FF);
    repeat (12) cycle(0, 1, 3, 2, 0, 0, 0);
    // Minimum period: 0 is treated as 1.
    repeat (10) cycle(0, 1, 0, 0, 0, 0, 0);
    // Slot switch and odd period mid-period.
    repeat (5) cycle(0, 1, 4, 0, 0, 0, 0);
    repeat (14) cycle(0, 1, 4, 3, 0, 0, 0);
    // Drop enable mid-period, then resume.
    repeat (2) cycle(0, 1, 5, 1, 0, 0, 0);
    repeat (3) cycle(0, 0, 5, 1, 1, 1, 16'hA5A5);
    repeat (16) cycle(0, 1, 5, 1, 0, 0, 0);
    // Longest period the counter supports.
    repeat (520) cycle(0, 1, 8'hFF, 2, 0, 0, 0);
    // Reset mid-period.
    cycle(1, 1, 2, 1, 0, 0, 0);
    repeat (10) cycle(0, 1, 2, 1, 0, 0, 0);

    en = 1'b1; pl = 8'd3; cs = 2'd0;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) pl = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) cs = 2'($urandom_range(0, 3));
      cycle(($urandom_range(0, 299) == 0), en, pl, cs, ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 16'($urandom));
    end

    repeat (3) cycle(0, 0, 3, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
